mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm_pkg.sv | 44 ++++
 rtl/mc_ctrl_decode.sv | 95 +++++++++
 rtl/mc_control_fsm.sv | 88 ++++++++
 tb/tb_mc_control_fsm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle CPU control FSM: state codes, opcodes
// and the datapath mux/ALU select values.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map from FSM state (plus memory handshake and opcode) to the
// datapath control word.
module mc_ctrl_decode
  import mc_control_fsm_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  input  logic [5:0] i_opcode,
  output logic       o_PCWrite,
  output logic       o_PCWriteCond,
  output logic       o_IorD,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_MemtoReg,
  output logic       o_IRWrite,
  output logic       o_ALUSrcA,
  output logic       o_RegWrite,
  output logic       o_RegDst,
  output logic [1:0] o_PCSource,
  output logic [1:0] o_ALUOp,
  output logic [1:0] o_ALUSrcB,
  output logic       o_illegal
);

  always_comb begin
    o_PCWrite     = 1'b0;
    o_PCWriteCond = 1'b0;
    o_IorD        = 1'b0;
    o_MemRead     = 1'b0;
    o_MemWrite    = 1'b0;
    o_MemtoReg    = 1'b0;
    o_IRWrite     = 1'b0;
    o_ALUSrcA     = 1'b0;
    o_RegWrite    = 1'b0;
    o_RegDst      = 1'b0;
    o_PCSource    = PCSRC_ALU;
    o_ALUOp       = ALUOP_ADD;
    o_ALUSrcB     = SRCB_REG;
    o_illegal     = 1'b0;
    case (i_state)
      ST_FETCH: begin
        o_MemRead = 1'b1;
        o_ALUSrcB = SRCB_FOUR;
        o_IRWrite = i_mem_ready;
        o_PCWrite = i_mem_ready;
      end
      ST_DECODE: begin
        o_ALUSrcB = SRCB_IMM_SH2;
        o_ALUOp   = ALUOP_ADD;
        o_illegal = !op_supported(i_opcode);
      end
      ST_MEMADR: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        o_MemRead = 1'b1;
        o_IorD    = 1'b1;
      end
      ST_MEMWB: begin
        o_RegWrite = 1'b1;
        o_MemtoReg = 1'b1;
      end
      ST_MEMWR: begin
        o_MemWrite = 1'b1;
        o_IorD     = 1'b1;
      end
      ST_EXEC: begin
        o_ALUSrcA = 1'b1;
        o_ALUOp   = ALUOP_FUNCT;
      end
      ST_RWB: begin
        o_RegWrite = 1'b1;
        o_RegDst   = 1'b1;
      end
      ST_BRANCH: begin
        o_ALUSrcA     = 1'b1;
        o_ALUOp       = ALUOP_SUB;
        o_PCWriteCond = 1'b1;
        o_PCSource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        o_PCWrite  = 1'b1;
        o_PCSource = PCSRC_JUMP;
      end
      ST_ADDIEX: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = SRCB_IMM;
      end
      ST_ADDIWB: o_RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control FSM: state register and next-state logic; the
// control word is decoded from the state by mc_ctrl_decode.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_PCWrite,
  output logic       o_PCWriteCond,
  output logic       o_IorD,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_MemtoReg,
  output logic       o_IRWrite,
  output logic       o_ALUSrcA,
  output logic       o_RegWrite,
  output logic       o_RegDst,
  output logic [1:0] o_PCSource,
  output logic [1:0] o_ALUOp,
  output logic [1:0] o_ALUSrcB,
  output logic [3:0] o_state,
  output logic       o_illegal
);

  state_e state_q, state_d;
  logic   mem_rdy;
  logic   unused_zero;

  assign mem_rdy = MEM_WAIT_EN ? i_mem_ready : 1'b1;
  // Branch resolution is PCWriteCond AND zero in the datapath, not here.
  assign unused_zero = i_zero;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = mem_rdy ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (i_opcode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (i_opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_d = mem_rdy ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_d = mem_rdy ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_d = ST_RWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  assign o_state = state_q;

  mc_ctrl_decode u_decode (
    .i_state       (state_q),
    .i_mem_ready   (mem_rdy),
    .i_opcode      (i_opcode),
    .o_PCWrite     (o_PCWrite),
    .o_PCWriteCond (o_PCWriteCond),
    .o_IorD        (o_IorD),
    .o_MemRead     (o_MemRead),
    .o_MemWrite    (o_MemWrite),
    .o_MemtoReg    (o_MemtoReg),
    .o_IRWrite     (o_IRWrite),
    .o_ALUSrcA     (o_ALUSrcA),
    .o_RegWrite    (o_RegWrite),
    .o_RegDst      (o_RegDst),
    .o_PCSource    (o_PCSource),
    .o_ALUOp       (o_ALUOp),
    .o_ALUSrcB     (o_ALUSrcB),
    .o_illegal     (o_illegal)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level vector table, directed corner
// sequences, and random traffic against a path-based reference model.
module tb_mc_control_fsm;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [5:0] i_opcode;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead, o_MemWrite;
  logic       o_MemtoReg, o_IRWrite, o_ALUSrcA, o_RegWrite, o_RegDst;
  logic [1:0] o_PCSource, o_ALUOp, o_ALUSrcB;
  logic [3:0] o_state;
  logic       o_illegal;

  mc_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_zero(i_zero),
    .i_mem_ready(i_mem_ready), .o_PCWrite(o_PCWrite), .o_PCWriteCond(o_PCWriteCond),
    .o_IorD(o_IorD), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
    .o_MemtoReg(o_MemtoReg), .o_IRWrite(o_IRWrite), .o_ALUSrcA(o_ALUSrcA),
    .o_RegWrite(o_RegWrite), .o_RegDst(o_RegDst), .o_PCSource(o_PCSource),
    .o_ALUOp(o_ALUOp), .o_ALUSrcB(o_ALUSrcB), .o_state(o_state), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  int mpath[$];

  typedef struct {
    logic [5:0] op;
    int fstall;
    int mstall;
    int cycles;
    int rw;
    int mw;
    int ill;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #2;
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // Expected state walk of one instruction; FETCH, MEMRD and MEMWR repeat while memory stalls.
  task automatic set_path(input logic [5:0] op);
    case (op)
      6'b100011: mpath = {0, 1, 2, 3, 4};
      6'b101011: mpath = {0, 1, 2, 5};
      6'b000000: mpath = {0, 1, 6, 7};
      6'b001000: mpath = {0, 1, 10, 11};
      6'b000100: mpath = {0, 1, 8};
      6'b000010: mpath = {0, 1, 9};
      default:   mpath = {0, 1};
    endcase
  endtask

  function automatic logic [16:0] exp_out(input int st, input bit rdy, input bit ill);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
    logic [1:0] pcs, aop, srcb;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst} = '0;
    pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
    case (st)
      0:  begin mrd = 1'b1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1:  srcb = 2'b11;
      2:  begin srca = 1'b1; srcb = 2'b10; end
      3:  begin mrd = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mwr = 1'b1; iord = 1'b1; end
      6:  begin srca = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rdst = 1'b1; end
      8:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      9:  begin pcw = 1'b1; pcs = 2'b10; end
      10: begin srca = 1'b1; srcb = 2'b10; end
      11: rw = 1'b1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst, pcs, aop, srcb, ill};
  endfunction

  function automatic logic [16:0] act_out();
    return {o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead, o_MemWrite, o_MemtoReg,
            o_IRWrite, o_ALUSrcA, o_RegWrite, o_RegDst, o_PCSource, o_ALUOp,
            o_ALUSrcB, o_illegal};
  endfunction

  task automatic run_instr(input logic [5:0] op, input int fst, input int mst,
                           output int cy, output int rw, output int mw, output int il);
    int fs, ms;
    bit left;
    cy = 0; rw = 0; mw = 0; il = 0; fs = 0; ms = 0; left = 1'b0;
    while (!(left && o_state == 4'd0) && cy < 50) begin
      i_opcode = op;
      i_mem_ready = 1'b1;
      if (o_state == 4'd0 && fs < fst) begin i_mem_ready = 1'b0; fs++; end
      if ((o_state == 4'd3 || o_state == 4'd5) && ms < mst) begin i_mem_ready = 1'b0; ms++; end
      #1;
      rw += int'(o_RegWrite);
      mw += int'(o_MemWrite);
      il += int'(o_illegal);
      cy++;
      cyc();
      if (o_state != 4'd0) left = 1'b1;
    end
  endtask

  task automatic check_seq(input string name, input logic [5:0] op, input int es[$]);
    for (int i = 0; i < es.size(); i++) begin
      if (i > 0) cyc();
      i_opcode = op;
      i_mem_ready = 1'b1;
      #1;
      chk({name, " state"}, int'(o_state), es[i]);
      chk({name, " RegWrite"}, int'(o_RegWrite), int'(es[i] == 4 || es[i] == 7 || es[i] == 11));
      chk({name, " MemWrite"}, int'(o_MemWrite), int'(es[i] == 5));
      chk({name, " illegal"}, int'(o_illegal), int'(es[i] == 1 && !legal(op)));
      if (es[i] == 4) chk({name, " MemtoReg"}, int'(o_MemtoReg), 1);
      if (es[i] == 7) chk({name, " RegDst rwb"}, int'(o_RegDst), 1);
      if (es[i] == 11) chk({name, " RegDst addiwb"}, int'(o_RegDst), 0);
      if (es[i] == 8) begin
        chk({name, " PCWriteCond"}, int'(o_PCWriteCond), 1);
        chk({name, " PCSource"}, int'(o_PCSource), 1);
        chk({name, " ALUOp"}, int'(o_ALUOp), 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cy, rw, mw, il, idx, es_state;
    int es[$];
    logic [5:0] cur_op;
    bit rdy;

    vecs.push_back('{6'b100011, 0, 0, 5, 1, 0, 0});
    vecs.push_back('{6'b101011, 0, 0, 4, 0, 1, 0});
    vecs.push_back('{6'b000000, 0, 0, 4, 1, 0, 0});
    vecs.push_back('{6'b001000, 0, 0, 4, 1, 0, 0});
    vecs.push_back('{6'b000100, 0, 0, 3, 0, 0, 0});
    vecs.push_back('{6'b000010, 0, 0, 3, 0, 0, 0});
    vecs.push_back('{6'b111111, 0, 0, 2, 0, 0, 1});
    vecs.push_back('{6'b000001, 0, 0, 2, 0, 0, 1});
    vecs.push_back('{6'b100011, 2, 3, 10, 1, 0, 0});
    vecs.push_back('{6'b101011, 0, 3, 7, 0, 4, 0});
    vecs.push_back('{6'b000000, 3, 0, 7, 1, 0, 0});
    vecs.push_back('{6'b000010, 1, 0, 4, 0, 0, 0});

    i_rst_n = 1'b0; i_opcode = 6'd0; i_zero = 1'b0; i_mem_ready = 1'b1;
    #1;
    cyc(); cyc();
    chk("reset state", int'(o_state), 0);
    chk("reset illegal", int'(o_illegal), 0);
    chk("reset outputs", int'(act_out()), int'(exp_out(0, 1'b1, 1'b0)));

    i_mem_ready = 1'b0;
    i_rst_n = 1'b1;
    #1;
    chk("fetch stall IRWrite", int'(o_IRWrite), 0);
    chk("fetch stall PCWrite", int'(o_PCWrite), 0);
    cyc();
    chk("first edge stalled fetch", int'(o_state), 0);
    i_mem_ready = 1'b1;
    #1;
    chk("fetch ready IRWrite", int'(o_IRWrite), 1);

    foreach (vecs[k]) begin
      run_instr(vecs[k].op, vecs[k].fstall, vecs[k].mstall, cy, rw, mw, il);
      chk($sformatf("vec%0d cycles", k), cy, vecs[k].cycles);
      chk($sformatf("vec%0d RegWrite count", k), rw, vecs[k].rw);
      chk($sformatf("vec%0d MemWrite count", k), mw, vecs[k].mw);
      chk($sformatf("vec%0d illegal count", k), il, vecs[k].ill);
    end

    es = {0, 1, 2, 3, 4, 0};
    check_seq("lw seq", 6'b100011, es);
    i_zero = 1'b1;
    es = {0, 1, 8, 0};
    check_seq("beq seq", 6'b000100, es);
    i_zero = 1'b0;
    es = {0, 1, 0};
    check_seq("illegal seq", 6'b111111, es);
    es = {0, 1, 6, 7, 0};
    check_seq("rtype seq", 6'b000000, es);
    es = {0, 1, 10, 11, 0};
    check_seq("addi seq", 6'b001000, es);

    // Asynchronous reset while sitting in RWB.
    es = {0, 1, 6, 7};
    check_seq("rtype abort", 6'b000000, es);
    i_rst_n = 1'b0;
    #1;
    chk("async rst state", int'(o_state), 0);
    chk("async rst RegWrite", int'(o_RegWrite), 0);
    chk("async rst MemWrite", int'(o_MemWrite), 0);
    #2;
    i_rst_n = 1'b1;
    i_opcode = 6'b111111;
    cyc();
    #1;
    chk("post rst fetch advanced", int'(o_state), 1);
    chk("post rst illegal", int'(o_illegal), 1);
    cyc();
    chk("post rst back to fetch", int'(o_state), 0);

    idx = 0;
    cur_op = 6'd0;
    for (int c = 0; c < 1500; c++) begin
      if (idx == 0) begin
        case ($urandom_range(0, 7))
          0: cur_op = 6'b100011;
          1: cur_op = 6'b101011;
          2: cur_op = 6'b000000;
          3: cur_op = 6'b001000;
          4: cur_op = 6'b000100;
          5: cur_op = 6'b000010;
          default: cur_op = 6'($urandom_range(0, 63));
        endcase
        set_path(cur_op);
      end
      rdy = ($urandom_range(0, 3) != 0);
      i_opcode = cur_op;
      i_mem_ready = rdy;
      i_zero = 1'($urandom_range(0, 1));
      #1;
      es_state = mpath[idx];
      chk("rand state", int'(o_state), es_state);
      chk("rand outputs", int'(act_out()),
          int'(exp_out(es_state, rdy, (es_state == 1) && !legal(cur_op))));
      cyc();
      if (!((es_state == 0 || es_state == 3 || es_state == 5) && !rdy)) idx++;
      if (idx == mpath.size()) idx = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
